// File: rtl/idli_uartx_m.sv
// idli_uartx_m: full-duplex UART with word-level TX/RX FIFOs and a
// nibble-serial core interface (LSB nibble first), configurable bit period,
// word width, FIFO depths, optional even parity and sticky error flags.
module idli_uartx_m #(
  parameter int unsigned CLK_DIV   = 16,
  parameter int unsigned WORD_W    = 16,
  parameter int unsigned TX_DEPTH  = 4,
  parameter int unsigned RX_DEPTH  = 4,
  parameter int unsigned PARITY_EN = 0
) (
  input  logic       i_uartx_gck,
  input  logic       i_uartx_rst,
  input  logic [3:0] i_uartx_tx_data,
  input  logic       i_uartx_tx_vld,
  output logic       o_uartx_tx_rdy,
  output logic       o_uartx_tx,
  input  logic       i_uartx_rx,
  output logic       o_uartx_rx_vld,
  input  logic       i_uartx_rx_acp,
  output logic [3:0] o_uartx_rx_data,
  output logic       o_uartx_rx_data_vld,
  output logic [2:0] o_uartx_err,
  input  logic       i_uartx_err_clr
);
  localparam int unsigned NIBS  = WORD_W / 4;
  localparam int unsigned BYTES = WORD_W / 8;
  localparam int unsigned NW    = $clog2(NIBS);
  localparam int unsigned BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int unsigned DW    = $clog2(CLK_DIV);
  localparam int unsigned TPW   = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
  localparam int unsigned RPW   = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
  localparam int unsigned TCW   = $clog2(TX_DEPTH + 1);
  localparam int unsigned RCW   = $clog2(RX_DEPTH + 1);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_st_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK} rx_st_e;

  // ---------------- TX nibble collector ----------------
  logic              col_q;
  logic [NW-1:0]     col_idx_q;
  logic [WORD_W-1:0] col_word_q, col_word_d;
  logic              tx_full, tx_empty, tx_push, tx_pop;

  assign o_uartx_tx_rdy = !tx_full && !col_q;
  assign tx_push        = col_q && i_uartx_tx_vld && (col_idx_q == NW'(NIBS - 1));

  // Merge the incoming nibble into the partially collected word.
  always_comb begin
    col_word_d = col_word_q;
    col_word_d[{col_idx_q, 2'b00} +: 4] = i_uartx_tx_data;
  end

  // Collect NIBS consecutive nibbles; a gap in tx_vld abandons the word.
  always_ff @(posedge i_uartx_gck or posedge i_uartx_rst) begin
    if (i_uartx_rst) begin
      col_q      <= 1'b0;
      col_idx_q  <= '0;
      col_word_q <= '0;
    end else if (!col_q) begin
      if (i_uartx_tx_vld && o_uartx_tx_rdy) begin
        col_q           <= 1'b1;
        col_idx_q       <= NW'(1);
        col_word_q[3:0] <= i_uartx_tx_data;
      end
    end else if (!i_uartx_tx_vld) begin
      col_q <= 1'b0;
    end else begin
      col_word_q <= col_word_d;
      if (tx_push) col_q <= 1'b0;
      else         col_idx_q <= col_idx_q + NW'(1);
    end
  end

  // ---------------- TX FIFO ----------------
  logic [WORD_W-1:0] tx_mem_q [TX_DEPTH];
  logic [TPW-1:0]    tx_wr_q, tx_rd_q;
  logic [TCW-1:0]    tx_cnt_q;

  assign tx_full  = (tx_cnt_q == TCW'(TX_DEPTH));
  assign tx_empty = (tx_cnt_q == '0);

  // TX FIFO storage; emptiness is governed by the counter, so no reset needed.
  always_ff @(posedge i_uartx_gck) begin
    if (tx_push) tx_mem_q[tx_wr_q] <= col_word_d;
  end

  // TX FIFO pointers and occupancy.
  always_ff @(posedge i_uartx_gck or posedge i_uartx_rst) begin
    if (i_uartx_rst) begin
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      tx_cnt_q <= '0;
    end else begin
      if (tx_push) tx_wr_q <= (tx_wr_q == TPW'(TX_DEPTH - 1)) ? '0 : tx_wr_q + TPW'(1);
      if (tx_pop)  tx_rd_q <= (tx_rd_q == TPW'(TX_DEPTH - 1)) ? '0 : tx_rd_q + TPW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt_q <= tx_cnt_q + TCW'(1);
        2'b01:   tx_cnt_q <= tx_cnt_q - TCW'(1);
        default: tx_cnt_q <= tx_cnt_q;
      endcase
    end
  end

  // ---------------- TX serialiser ----------------
  tx_st_e            tx_st_q;
  logic [DW-1:0]     tx_div_q;
  logic [2:0]        tx_bit_q;
  logic [BW-1:0]     tx_byte_q;
  logic [WORD_W-1:0] tx_sh_q;
  logic              tx_par_q, tx_q, tx_bit_end, tx_last_byte;

  assign tx_bit_end   = (tx_div_q == DW'(CLK_DIV - 1));
  assign tx_last_byte = (tx_byte_q == BW'(BYTES - 1));
  assign tx_pop       = !tx_empty && ((tx_st_q == TX_IDLE) ||
                        (tx_st_q == TX_STOP && tx_bit_end && tx_last_byte));
  assign o_uartx_tx   = tx_q;

  // Frame each byte LSB first; words chain back-to-back out of the FIFO.
  always_ff @(posedge i_uartx_gck or posedge i_uartx_rst) begin
    if (i_uartx_rst) begin
      tx_st_q   <= TX_IDLE;
      tx_div_q  <= '0;
      tx_bit_q  <= '0;
      tx_byte_q <= '0;
      tx_sh_q   <= '0;
      tx_par_q  <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      tx_div_q <= tx_bit_end ? '0 : tx_div_q + DW'(1);
      case (tx_st_q)
        TX_IDLE: begin
          tx_div_q <= '0;
          tx_q     <= 1'b1;
          if (tx_pop) begin
            tx_st_q   <= TX_START;
            tx_q      <= 1'b0;
            tx_sh_q   <= tx_mem_q[tx_rd_q];
            tx_byte_q <= '0;
          end
        end
        TX_START: if (tx_bit_end) begin
          tx_st_q  <= TX_DATA;
          tx_bit_q <= '0;
          tx_q     <= tx_sh_q[0];
          tx_par_q <= tx_sh_q[0];
        end
        TX_DATA: if (tx_bit_end) begin
          // Shifting once per data bit leaves the next byte in [7:0].
          tx_sh_q <= tx_sh_q >> 1;
          if (tx_bit_q == 3'd7) begin
            if (PARITY_EN != 0) begin
              tx_st_q <= TX_PARITY;
              tx_q    <= tx_par_q;
            end else begin
              tx_st_q <= TX_STOP;
              tx_q    <= 1'b1;
            end
          end else begin
            tx_bit_q <= tx_bit_q + 3'd1;
            tx_q     <= tx_sh_q[1];
            tx_par_q <= tx_par_q ^ tx_sh_q[1];
          end
        end
        TX_PARITY: if (tx_bit_end) begin
          tx_st_q <= TX_STOP;
          tx_q    <= 1'b1;
        end
        TX_STOP: if (tx_bit_end) begin
          if (!tx_last_byte) begin
            tx_st_q   <= TX_START;
            tx_q      <= 1'b0;
            tx_byte_q <= tx_byte_q + BW'(1);
          end else if (tx_pop) begin
            tx_st_q   <= TX_START;
            tx_q      <= 1'b0;
            tx_sh_q   <= tx_mem_q[tx_rd_q];
            tx_byte_q <= '0;
          end else begin
            tx_st_q <= TX_IDLE;
          end
        end
        default: tx_st_q <= TX_IDLE;
      endcase
    end
  end

  // ---------------- RX deserialiser ----------------
  logic              rx_s1_q, rx_s2_q, rx_s3_q;
  rx_st_e            rx_st_q;
  logic [DW-1:0]     rx_div_q;
  logic [2:0]        rx_bit_q;
  logic [7:0]        rx_byte_q;
  logic [BW-1:0]     rx_bidx_q;
  logic [WORD_W-1:0] rx_word_q;
  logic              rx_par_q, rx_perr_q, rx_push_q, rx_bit_end, rx_half;
  logic              par_set, frm_set, ovr_set;

  assign rx_bit_end = (rx_div_q == DW'(CLK_DIV - 1));
  assign rx_half    = (rx_div_q == DW'(CLK_DIV / 2 - 1));
  assign par_set    = (rx_st_q == RX_PARITY) && rx_bit_end && (rx_s2_q != rx_par_q);
  assign frm_set    = (rx_st_q == RX_STOP) && rx_bit_end && !rx_s2_q;

  // Two-flop synchroniser plus one history flop for falling-edge detection.
  always_ff @(posedge i_uartx_gck or posedge i_uartx_rst) begin
    if (i_uartx_rst) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_s3_q <= 1'b1;
    end else begin
      rx_s1_q <= i_uartx_rx;
      rx_s2_q <= rx_s1_q;
      rx_s3_q <= rx_s2_q;
    end
  end

  // Mid-bit sampling; any errored byte throws away the partial word.
  always_ff @(posedge i_uartx_gck or posedge i_uartx_rst) begin
    if (i_uartx_rst) begin
      rx_st_q   <= RX_IDLE;
      rx_div_q  <= '0;
      rx_bit_q  <= '0;
      rx_byte_q <= '0;
      rx_bidx_q <= '0;
      rx_word_q <= '0;
      rx_par_q  <= 1'b0;
      rx_perr_q <= 1'b0;
      rx_push_q <= 1'b0;
    end else begin
      rx_push_q <= 1'b0;
      rx_div_q  <= rx_bit_end ? '0 : rx_div_q + DW'(1);
      case (rx_st_q)
        RX_IDLE: begin
          rx_div_q <= '0;
          if (rx_s3_q && !rx_s2_q) rx_st_q <= RX_START;
        end
        RX_START: if (rx_half) begin
          rx_div_q  <= '0;
          rx_bit_q  <= '0;
          rx_par_q  <= 1'b0;
          rx_perr_q <= 1'b0;
          rx_st_q   <= rx_s2_q ? RX_IDLE : RX_DATA;
        end
        RX_DATA: if (rx_bit_end) begin
          rx_byte_q <= {rx_s2_q, rx_byte_q[7:1]};
          rx_par_q  <= rx_par_q ^ rx_s2_q;
          rx_bit_q  <= rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_st_q <= (PARITY_EN != 0) ? RX_PARITY : RX_STOP;
        end
        RX_PARITY: if (rx_bit_end) begin
          rx_perr_q <= par_set;
          rx_st_q   <= RX_STOP;
        end
        RX_STOP: if (rx_bit_end) begin
          if (!rx_s2_q) begin
            rx_bidx_q <= '0;
            rx_st_q   <= RX_BREAK;
          end else begin
            rx_st_q <= RX_IDLE;
            if (rx_perr_q) begin
              rx_bidx_q <= '0;
            end else begin
              rx_word_q[{rx_bidx_q, 3'b000} +: 8] <= rx_byte_q;
              if (rx_bidx_q == BW'(BYTES - 1)) begin
                rx_bidx_q <= '0;
                rx_push_q <= 1'b1;
              end else begin
                rx_bidx_q <= rx_bidx_q + BW'(1);
              end
            end
          end
        end
        RX_BREAK: if (rx_s2_q) rx_st_q <= RX_IDLE;
        default: rx_st_q <= RX_IDLE;
      endcase
    end
  end

  // ---------------- RX FIFO and readout ----------------
  logic [WORD_W-1:0] rx_mem_q [RX_DEPTH];
  logic [RPW-1:0]    rx_wr_q, rx_rd_q;
  logic [RCW-1:0]    rx_cnt_q;
  logic              rx_full, rx_empty, rx_wr_en, rx_pop, rd_act_q;
  logic [NW-1:0]     rd_idx_q, rd_idx_nxt;
  logic [3:0]        rd_dat_q;
  logic [WORD_W-1:0] rx_head;

  assign rx_full             = (rx_cnt_q == RCW'(RX_DEPTH));
  assign rx_empty            = (rx_cnt_q == '0);
  assign rx_pop              = rd_act_q && (rd_idx_q == NW'(NIBS - 1));
  assign rx_wr_en            = rx_push_q && (!rx_full || rx_pop);
  assign ovr_set             = rx_push_q && rx_full && !rx_pop;
  assign rx_head             = rx_mem_q[rx_rd_q];
  assign rd_idx_nxt          = rd_idx_q + NW'(1);
  assign o_uartx_rx_vld      = !rx_empty && !rd_act_q;
  assign o_uartx_rx_data     = rd_dat_q;
  assign o_uartx_rx_data_vld = rd_act_q;

  // RX FIFO storage.
  always_ff @(posedge i_uartx_gck) begin
    if (rx_wr_en) rx_mem_q[rx_wr_q] <= rx_word_q;
  end

  // RX FIFO pointers and occupancy; a full FIFO popped this cycle still accepts.
  always_ff @(posedge i_uartx_gck or posedge i_uartx_rst) begin
    if (i_uartx_rst) begin
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      rx_cnt_q <= '0;
    end else begin
      if (rx_wr_en) rx_wr_q <= (rx_wr_q == RPW'(RX_DEPTH - 1)) ? '0 : rx_wr_q + RPW'(1);
      if (rx_pop)   rx_rd_q <= (rx_rd_q == RPW'(RX_DEPTH - 1)) ? '0 : rx_rd_q + RPW'(1);
      case ({rx_wr_en, rx_pop})
        2'b10:   rx_cnt_q <= rx_cnt_q + RCW'(1);
        2'b01:   rx_cnt_q <= rx_cnt_q - RCW'(1);
        default: rx_cnt_q <= rx_cnt_q;
      endcase
    end
  end

  // Stream the head word to the core one nibble per cycle after an accept.
  always_ff @(posedge i_uartx_gck or posedge i_uartx_rst) begin
    if (i_uartx_rst) begin
      rd_act_q <= 1'b0;
      rd_idx_q <= '0;
      rd_dat_q <= '0;
    end else if (rd_act_q) begin
      if (rx_pop) begin
        rd_act_q <= 1'b0;
        rd_dat_q <= '0;
      end else begin
        rd_idx_q <= rd_idx_nxt;
        rd_dat_q <= rx_head[{rd_idx_nxt, 2'b00} +: 4];
      end
    end else if (i_uartx_rx_acp && o_uartx_rx_vld) begin
      rd_act_q <= 1'b1;
      rd_idx_q <= '0;
      rd_dat_q <= rx_head[3:0];
    end
  end

  // Sticky errors; a new error in the clearing cycle survives the clear.
  always_ff @(posedge i_uartx_gck or posedge i_uartx_rst) begin
    if (i_uartx_rst) o_uartx_err <= '0;
    else o_uartx_err <= (i_uartx_err_clr ? 3'b000 : o_uartx_err) | {ovr_set, par_set, frm_set};
  end

endmodule

// File: tb/tb_idli_uartx_m.sv
// Directed bench for idli_uartx_m: u0 (TX_DEPTH=2, no parity) covers TX, RX,
// overrun, glitch/framing and reset; u1 (PARITY_EN=1) covers parity.
`timescale 1ns/1ps
module tb_idli_uartx_m;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] tx_data0, tx_data1, rx_data0, rx_data1;
  logic       tx_vld0, tx_vld1, tx_rdy0, tx_rdy1, tx0, tx1, rx0, rx1;
  logic       rx_vld0, rx_vld1, acp0, acp1, dv0, dv1, clr0, clr1;
  logic [2:0] err0, err1;

  idli_uartx_m #(.TX_DEPTH(2)) u0 (
    .i_uartx_gck(clk), .i_uartx_rst(rst),
    .i_uartx_tx_data(tx_data0), .i_uartx_tx_vld(tx_vld0), .o_uartx_tx_rdy(tx_rdy0),
    .o_uartx_tx(tx0), .i_uartx_rx(rx0), .o_uartx_rx_vld(rx_vld0),
    .i_uartx_rx_acp(acp0), .o_uartx_rx_data(rx_data0), .o_uartx_rx_data_vld(dv0),
    .o_uartx_err(err0), .i_uartx_err_clr(clr0));

  idli_uartx_m #(.PARITY_EN(1)) u1 (
    .i_uartx_gck(clk), .i_uartx_rst(rst),
    .i_uartx_tx_data(tx_data1), .i_uartx_tx_vld(tx_vld1), .o_uartx_tx_rdy(tx_rdy1),
    .o_uartx_tx(tx1), .i_uartx_rx(rx1), .o_uartx_rx_vld(rx_vld1),
    .i_uartx_rx_acp(acp1), .o_uartx_rx_data(rx_data1), .o_uartx_rx_data_vld(dv1),
    .o_uartx_err(err1), .i_uartx_err_clr(clr1));

  int total = 0;
  int bad   = 0;
  logic [7:0] mon_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_rx(input bit sel, input logic v);
    if (sel) rx1 = v; else rx0 = v;
  endtask

  task automatic send_bit(input bit sel, input logic v);
    set_rx(sel, v);
    repeat (16) tick();
  endtask

  task automatic send_byte(input bit sel, input logic [7:0] b, input bit usepar,
                           input logic pbit, input logic stopv);
    send_bit(sel, 1'b0);
    for (int k = 0; k < 8; k++) send_bit(sel, b[k]);
    if (usepar) send_bit(sel, pbit);
    send_bit(sel, stopv);
    set_rx(sel, 1'b1);
  endtask

  task automatic send_word0(input logic [15:0] w);
    send_byte(1'b0, w[7:0], 1'b0, 1'b0, 1'b1);
    send_byte(1'b0, w[15:8], 1'b0, 1'b0, 1'b1);
  endtask

  task automatic read_word0(input string tag, input logic [15:0] exp);
    chk({tag, "_vld"}, rx_vld0, 1);
    acp0 = 1'b1;
    tick();
    acp0 = 1'b0;
    chk({tag, "_vld_busy"}, rx_vld0, 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_dv%0d", tag, i), dv0, 1);
      chk($sformatf("%s_nib%0d", tag, i), rx_data0, exp[i*4 +: 4]);
      tick();
    end
    chk({tag, "_dv_end"}, dv0, 0);
  endtask

  task automatic wait_rdy0(input string tag, output int n);
    n = 0;
    while (!tx_rdy0 && n < 600) begin tick(); n++; end
    chk({tag, "_rdy_to"}, tx_rdy0, 1);
  endtask

  task automatic push_word0(input string tag, input logic [15:0] w, input int nn);
    int n;
    wait_rdy0(tag, n);
    for (int i = 0; i < nn; i++) begin
      tx_vld0  = 1'b1;
      tx_data0 = w[i*4 +: 4];
      tick();
    end
    tx_vld0 = 1'b0;
  endtask

  // Line monitor for u0's TX output, sampling each bit at its centre.
  initial begin
    logic       prev;
    logic [7:0] mb;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (prev === 1'b1 && tx0 === 1'b0) begin
        repeat (8) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
          repeat (16) @(negedge clk);
          mb[k] = tx0;
        end
        repeat (16) @(negedge clk);
        mon_q.push_back(mb);
      end
      prev = tx0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] wa;
    logic [7:0]  frame;
    logic [7:0]  exp_bytes [8];
    int n;
    tx_data0 = '0; tx_data1 = '0; tx_vld0 = 0; tx_vld1 = 0;
    rx0 = 1; rx1 = 1; acp0 = 0; acp1 = 0; clr0 = 0; clr1 = 0;
    #1 rst = 1'b1;
    repeat (3) tick();
    chk("rst_tx", tx0, 1);
    chk("rst_rdy", tx_rdy0, 1);
    chk("rst_rxvld", rx_vld0, 0);
    chk("rst_rxdata", rx_data0, 0);
    chk("rst_dv", dv0, 0);
    chk("rst_err", err0, 0);
    rst = 1'b0;
    repeat (4) tick();

    // TX word 0xA55A: start bit at N+2, 20 bit slots, idle afterwards.
    wa = 16'hA55A;
    push_word0("txa", wa, 4);
    chk("tx_n1", tx0, 1);
    tick();
    chk("tx_n2", tx0, 0);
    repeat (8) tick();
    for (int s = 0; s < 20; s++) begin
      frame = (s < 10) ? wa[7:0] : wa[15:8];
      if (s % 10 == 0)      chk($sformatf("tx_slot%0d", s), tx0, 0);
      else if (s % 10 == 9) chk($sformatf("tx_slot%0d", s), tx0, 1);
      else                  chk($sformatf("tx_slot%0d", s), tx0, frame[(s % 10) - 1]);
      if (s != 19) repeat (16) tick();
    end
    repeat (8) tick();
    chk("tx_end320", tx0, 1);
    repeat (20) tick();
    chk("tx_idle", tx0, 1);

    // RX word from bytes 0x34, 0x12.
    send_word0(16'h1234);
    n = 0;
    while (!rx_vld0 && n < 40) begin tick(); n++; end
    read_word0("rx1234", 16'h1234);
    chk("rx1234_empty", rx_vld0, 0);

    // Overrun: five words into a four-deep FIFO.
    send_word0(16'hBEEF);
    send_word0(16'h0123);
    send_word0(16'hCAFE);
    send_word0(16'h8001);
    chk("ovr_pre_err", err0, 3'b000);
    send_word0(16'h7E57);
    chk("ovr_err", err0, 3'b100);
    read_word0("ovr_w0", 16'hBEEF);
    read_word0("ovr_w1", 16'h0123);
    read_word0("ovr_w2", 16'hCAFE);
    read_word0("ovr_w3", 16'h8001);
    chk("ovr_empty", rx_vld0, 0);
    clr0 = 1'b1; tick(); clr0 = 1'b0;
    chk("ovr_clr", err0, 3'b000);

    // Short low pulse is a glitch, not an error.
    set_rx(1'b0, 1'b0);
    repeat (4) tick();
    set_rx(1'b0, 1'b1);
    repeat (40) tick();
    chk("glitch_err", err0, 3'b000);
    chk("glitch_vld", rx_vld0, 0);

    // Good byte then framing error: partial word must be discarded.
    send_byte(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
    send_byte(1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
    repeat (20) tick();
    chk("frm_err", err0, 3'b001);
    chk("frm_vld", rx_vld0, 0);
    clr0 = 1'b1; tick(); clr0 = 1'b0;
    chk("frm_clr", err0, 3'b000);
    send_word0(16'h2468);
    read_word0("frm_after", 16'h2468);

    // Parity instance: wrong parity on 0x07, then a correct word 0x0007.
    send_byte(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
    repeat (4) tick();
    chk("par_err", err1, 3'b010);
    chk("par_novld", rx_vld1, 0);
    clr1 = 1'b1; tick(); clr1 = 1'b0;
    chk("par_clr", err1, 3'b000);
    send_byte(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
    send_byte(1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
    chk("par_vld", rx_vld1, 1);
    chk("par_ok_err", err1, 3'b000);
    acp1 = 1'b1; tick(); acp1 = 1'b0;
    chk("par_dv", dv1, 1);
    chk("par_nib0", rx_data1, 4'h7);
    tick();
    chk("par_nib1", rx_data1, 4'h0);
    repeat (3) tick();
    chk("par_dv_end", dv1, 0);
    chk("par_empty", rx_vld1, 0);

    // TX_DEPTH=2 back-pressure, dropped partial word, then mid-frame reset.
    mon_q.delete();
    push_word0("bpa", 16'h1234, 4);
    push_word0("bpb", 16'h5678, 4);
    push_word0("bpc", 16'h9ABC, 4);
    chk("bp_rdy_low", tx_rdy0, 0);
    wait_rdy0("bp_wait", n);
    chk("bp_wait_cycles", n, 313);
    push_word0("drop", 16'hFFEE, 2);
    push_word0("bpe", 16'h4321, 4);
    n = 0;
    while (mon_q.size() < 8 && n < 1500) begin tick(); n++; end
    chk("bp_bytes", mon_q.size(), 8);
    exp_bytes = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A, 8'h21, 8'h43};
    for (int i = 0; i < 8; i++)
      if (i < mon_q.size()) chk($sformatf("bp_byte%0d", i), mon_q[i], exp_bytes[i]);
    push_word0("rstw", 16'h0FF0, 4);
    n = 0;
    while (tx0 && n < 100) begin tick(); n++; end
    chk("rst_start", tx0, 0);
    repeat (40) tick();
    rst = 1'b1;
    #1;
    chk("midrst_tx", tx0, 1);
    chk("midrst_rdy", tx_rdy0, 1);
    tick();
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 400; i++) begin
      if (tx0 !== 1'b1) n++;
      tick();
    end
    chk("midrst_idle", n, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
